i2c_slave_tx_sequencer: RTL and testbench
=========================================

# i2c_slave_tx_sequencer

Sequences the I2C slave transmit (master-read) path. After the address decoder grants a read transfer, the block fetches bytes from the slave register file and hands them one at a time to `I2C_slave_write_byte`. It releases SDA for the master's ACK bit, samples ACK/NACK, and either continues with the next register (auto-increment, wrap-around) or ends the transfer. It sits between the slave address/protocol FSM, the register file read port and the byte writer.

## Interface
- `ADDR_WIDTH`, 4, register pointer width; register file depth is 2^ADDR_WIDTH.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_start`  in  1  one-cycle pulse: address matched with R/W=1, start transmitting; honoured only in IDLE.
- `start_ptr`  in  ADDR_WIDTH  first register address, sampled with `tx_start`.
- `stop_det`  in  1  STOP or repeated START seen on bus; aborts the transfer.
- `scl_i`  in  1  SCL, already synchronised to `clk`.
- `sda_i`  in  1  SDA bus level, used for ACK sampling.
- `reg_rd_en`  out  1  register file read strobe.
- `reg_rd_addr`  out  ADDR_WIDTH  read address.
- `reg_rd_data`  in  8  read data, valid the cycle after `reg_rd_en`.
- `byte_write_en`  out  1  enable to the byte writer.
- `byte_write_o`  out  8  byte to the writer's `byte_write_i`.
- `byte_write_finish`  in  1  writer has shifted out all 8 bits.
- `sda_release`  out  1  1 = slave must not drive SDA (idle/ACK slot).
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.
- `nack_end`  out  1  1 = last transfer ended by master NACK, 0 = aborted by `stop_det`. Held until the next `tx_start`.
- `byte_cnt`  out  8  bytes completed in the current transfer, saturating at 255.

## Operation
- SCL edges: `scl_last` register resets to 1.
  - Rise = `~scl_last & scl_i`.
  - Fall = `scl_last & ~scl_i`.
- States: IDLE, RD_REQ, RD_CAP, SEND, ACK_RISE, ACK_FALL.
- IDLE:
  - `sda_release`=1, `busy`=0.
  - On `tx_start`: pointer<=`start_ptr`, `byte_cnt`<=0, `nack_end`<=0 → RD_REQ.
- RD_REQ: `reg_rd_en`=1, `reg_rd_addr`=pointer → RD_CAP.
- RD_CAP: capture `reg_rd_data` into `byte_write_o`, set `byte_write_en`=1, `sda_release`=0 → SEND.
- SEND: hold `byte_write_en` until `byte_write_finish`. Then:
  - `byte_write_en`<=0, `sda_release`<=1.
  - `byte_cnt`++ (saturating).
  - pointer<=pointer+1 (mod 2^ADDR_WIDTH).
  - Issue prefetch `reg_rd_en`=1 at the new pointer for one cycle; capture data into a prefetch register the following cycle.
  - → ACK_RISE.
- ACK_RISE: on SCL rise, latch ack = ~`sda_i` → ACK_FALL.
- ACK_FALL: on SCL fall:
  - ACK: `byte_write_o`<=prefetch, `byte_write_en`<=1, `sda_release`<=0 → SEND.
  - NACK: `done` pulse, `nack_end`<=1 → IDLE.
- `stop_det` in any non-IDLE state:
  - Next cycle: IDLE, `byte_write_en`=0, `sda_release`=1, `done` pulse, `nack_end`=0.
  - `stop_det` wins over a simultaneous `byte_write_finish` or SCL edge; `byte_cnt` is not incremented in that case.
- `tx_start` outside IDLE is ignored.
- `byte_write_o` holds its last value in IDLE.
- Reset (any time, asynchronous) returns to IDLE with reset values:
  - `byte_write_en`=0, `byte_write_o`=0.
  - `reg_rd_en`=0, `reg_rd_addr`=0.
  - `sda_release`=1, `busy`=0, `done`=0, `nack_end`=0, `byte_cnt`=0.

## Timing
- All outputs are registered.
- `tx_start` sampled high at edge T:
  - T+1: `reg_rd_en`=1, `busy`=1.
  - T+2: read data valid.
  - T+3: `byte_write_en`=1 with the byte.
- `byte_write_en` drops on the first edge after `byte_write_finish` is sampled high.
- The prefetch read completes 2 cycles after finish. Requirement: SCL high and low phases ≥ 2 clk each.
- Next byte's `byte_write_en` rises one cycle after the ACK-slot SCL fall is detected.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.

## Test plan
- Single byte: mem[2]=0xA5, `start_ptr`=2, master NACK → SDA bits 10100101, `reg_rd_addr` 2 then 3 (prefetch), `done` 1 cycle, `nack_end`=1, `byte_cnt`=1.
- Burst: mem[5..8]=0x11,0x22,0x33,0x44, `start_ptr`=5, ACK×3 then NACK → bytes in order, `byte_cnt`=4, `sda_release`=1 during each ACK slot only.
- Wrap: `start_ptr`=15, mem[15]=0xF0, mem[0]=0x0F, ACK then NACK → second byte 0x0F from address 0.
- Abort: `stop_det` after 3 bits of byte 0 → next cycle IDLE, `byte_write_en`=0, `sda_release`=1, `done` pulse, `nack_end`=0, `byte_cnt`=0. Same check with `stop_det` coincident with `byte_write_finish` → `byte_cnt` unchanged.
- `tx_start` pulsed mid-SEND → ignored, transfer unaffected.
- Reset asserted mid-SEND → all outputs at reset values immediately; a following `tx_start` transfers normally.

Source files
------------

// File: rtl/i2c_slave_tx_sequencer.sv
// I2C slave transmit sequencer: fetches register bytes, feeds the byte
// writer and runs the master ACK/NACK slot with pointer auto-increment.
module i2c_slave_tx_sequencer #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_start,
    input  logic [ADDR_WIDTH-1:0] start_ptr,
    input  logic                  stop_det,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  reg_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [7:0]            reg_rd_data,
    output logic                  byte_write_en,
    output logic [7:0]            byte_write_o,
    input  logic                  byte_write_finish,
    output logic                  sda_release,
    output logic                  busy,
    output logic                  done,
    output logic                  nack_end,
    output logic [7:0]            byte_cnt
);
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        SEND,
        ACK_RISE,
        ACK_FALL
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [7:0]            pf_q, pf_d, bw_o_d, cnt_d;
    logic                  pf_cap_q, pf_cap_d;
    logic                  ack_q, ack_d;
    logic                  scl_last, scl_rise, scl_fall;
    logic                  rd_en_d, bw_en_d, rel_d;
    logic                  busy_d, done_d, nack_d;

    assign scl_rise = ~scl_last & scl_i;
    assign scl_fall = scl_last & ~scl_i;
    assign ptr_inc  = ptr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pf_d      = pf_cap_q ? reg_rd_data : pf_q;
        pf_cap_d  = 1'b0;
        ack_d     = ack_q;
        rd_en_d   = 1'b0;
        rd_addr_d = reg_rd_addr;
        bw_en_d   = byte_write_en;
        bw_o_d    = byte_write_o;
        rel_d     = sda_release;
        busy_d    = busy;
        done_d    = 1'b0;
        nack_d    = nack_end;
        cnt_d     = byte_cnt;
        // A bus STOP/Sr overrides any finish or SCL edge in the same cycle
        if (stop_det && state_q != IDLE) begin
            state_d = IDLE;
            bw_en_d = 1'b0;
            rel_d   = 1'b1;
            done_d  = 1'b1;
            nack_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        ptr_d     = start_ptr;
                        rd_addr_d = start_ptr;
                        rd_en_d   = 1'b1;
                        cnt_d     = 8'd0;
                        nack_d    = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
                RD_REQ: state_d = RD_CAP;
                RD_CAP: begin
                    bw_o_d  = reg_rd_data;
                    bw_en_d = 1'b1;
                    rel_d   = 1'b0;
                    state_d = SEND;
                end
                SEND: begin
                    if (byte_write_finish) begin
                        bw_en_d   = 1'b0;
                        rel_d     = 1'b1;
                        cnt_d     = (byte_cnt == 8'hFF) ? byte_cnt
                                                        : byte_cnt + 8'd1;
                        ptr_d     = ptr_inc;
                        rd_addr_d = ptr_inc;
                        rd_en_d   = 1'b1;
                        state_d   = ACK_RISE;
                    end
                end
                ACK_RISE: begin
                    pf_cap_d = reg_rd_en;
                    if (scl_rise) begin
                        ack_d   = ~sda_i;
                        state_d = ACK_FALL;
                    end
                end
                ACK_FALL: begin
                    if (scl_fall) begin
                        if (ack_q) begin
                            bw_o_d  = pf_q;
                            bw_en_d = 1'b1;
                            rel_d   = 1'b0;
                            state_d = SEND;
                        end else begin
                            done_d  = 1'b1;
                            nack_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            pf_q          <= 8'd0;
            pf_cap_q      <= 1'b0;
            ack_q         <= 1'b0;
            scl_last      <= 1'b1;
            reg_rd_en     <= 1'b0;
            reg_rd_addr   <= '0;
            byte_write_en <= 1'b0;
            byte_write_o  <= 8'd0;
            sda_release   <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            nack_end      <= 1'b0;
            byte_cnt      <= 8'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pf_q          <= pf_d;
            pf_cap_q      <= pf_cap_d;
            ack_q         <= ack_d;
            scl_last      <= scl_i;
            reg_rd_en     <= rd_en_d;
            reg_rd_addr   <= rd_addr_d;
            byte_write_en <= bw_en_d;
            byte_write_o  <= bw_o_d;
            sda_release   <= rel_d;
            busy          <= busy_d;
            done          <= done_d;
            nack_end      <= nack_d;
            byte_cnt      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_i2c_slave_tx_sequencer.sv
// Self-checking bench for i2c_slave_tx_sequencer: bench plays master,
// register file and byte writer; expectations come from a transfer model.
module tb_i2c_slave_tx_sequencer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_start = 1'b0;
    logic [AW-1:0] start_ptr = '0;
    logic          stop_det = 1'b0;
    logic          scl_i = 1'b1;
    logic          sda_i = 1'b1;
    logic          reg_rd_en;
    logic [AW-1:0] reg_rd_addr;
    logic [7:0]    reg_rd_data = 8'd0;
    logic          byte_write_en;
    logic [7:0]    byte_write_o;
    logic          byte_write_finish = 1'b0;
    logic          sda_release, busy, done, nack_end;
    logic [7:0]    byte_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0]    mem [16];
    logic [AW-1:0] rd_log [$];
    logic [7:0]    obs_bytes [$];
    int obs_rel_bad, obs_ack_bad, obs_done, obs_busy_bad, obs_timeout;

    always #5 clk = ~clk;

    i2c_slave_tx_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start),
        .start_ptr(start_ptr), .stop_det(stop_det), .scl_i(scl_i),
        .sda_i(sda_i), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .byte_write_en(byte_write_en),
        .byte_write_o(byte_write_o),
        .byte_write_finish(byte_write_finish),
        .sda_release(sda_release), .busy(busy), .done(done),
        .nack_end(nack_end), .byte_cnt(byte_cnt)
    );

    // register file: one-cycle read latency
    always @(posedge clk) begin
        if (reg_rd_en === 1'b1) begin
            reg_rd_data <= mem[reg_rd_addr];
            rd_log.push_back(reg_rd_addr);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (byte_write_en === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic shift_bits(input int nbits, input bit glitch);
        for (int b = 0; b < nbits; b++) begin
            scl_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (sda_release !== 1'b0 || byte_write_en !== 1'b1)
                    obs_rel_bad++;
                tx_start = glitch && b == 3 && k == 0;
                if (tx_start) start_ptr = ~start_ptr;
            end
            scl_i = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (sda_release !== 1'b0 || byte_write_en !== 1'b1)
                    obs_rel_bad++;
            end
        end
    endtask

    task automatic do_transfer(input logic [AW-1:0] sp, input int n,
                               input bit glitch);
        bit ok;
        obs_bytes.delete();
        rd_log.delete();
        obs_rel_bad = 0; obs_ack_bad = 0; obs_done = 0;
        obs_busy_bad = 0; obs_timeout = 0;
        start_ptr = sp;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_en(ok);
            if (!ok) begin
                obs_timeout++;
                return;
            end
            obs_bytes.push_back(byte_write_o);
            shift_bits(8, glitch && i == 0);
            scl_i = 1'b0;
            byte_write_finish = 1'b1;
            @(negedge clk);
            byte_write_finish = 1'b0;
            cyc(2);
            if (sda_release !== 1'b1 || byte_write_en !== 1'b0)
                obs_ack_bad++;
            sda_i = (i == n - 1);
            scl_i = 1'b1;
            cyc(3);
            if (sda_release !== 1'b1) obs_ack_bad++;
            scl_i = 1'b0;
            sda_i = 1'b1;
            if (i == n - 1) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (done === 1'b1) begin
                        obs_done++;
                        if (busy !== 1'b0) obs_busy_bad++;
                    end
                end
                scl_i = 1'b1;
                cyc(2);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({reg_rd_en, reg_rd_addr, byte_write_en, byte_write_o}
            !== {1'b0, 4'h0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_rd_bw: got %b/%h/%b/%h want 0/0/0/00",
                     reg_rd_en, reg_rd_addr, byte_write_en, byte_write_o);
        end
        checks++;
        if ({sda_release, busy, done, nack_end} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got rel=%b busy=%b done=%b nack=%b want 1000",
                     sda_release, busy, done, nack_end);
        end
        checks++;
        if (byte_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d want 0", byte_cnt);
        end
    endtask

    task automatic test_single();
        fill_mem();
        mem[2] = 8'hA5;
        do_transfer(4'd2, 1, 1'b0);
        checks++;
        if (obs_bytes.size() != 1 || obs_bytes[0] !== 8'hA5) begin
            failures++;
            $display("FAIL single_byte: got %p want A5", obs_bytes);
        end
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 4'd2 || rd_log[1] !== 4'd3) begin
            failures++;
            $display("FAIL single_addr: got %p want 2,3", rd_log);
        end
        checks++;
        if (obs_done != 1 || obs_busy_bad != 0) begin
            failures++;
            $display("FAIL single_done: got pulses=%0d busy_bad=%0d want 1,0",
                     obs_done, obs_busy_bad);
        end
        checks++;
        if (nack_end !== 1'b1 || byte_cnt !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_end: got nack=%b cnt=%0d busy=%b want 1,1,0",
                     nack_end, byte_cnt, busy);
        end
        checks++;
        if (obs_rel_bad != 0 || obs_ack_bad != 0 || obs_timeout != 0) begin
            failures++;
            $display("FAIL single_release: got rel_bad=%0d ack_bad=%0d to=%0d want 0",
                     obs_rel_bad, obs_ack_bad, obs_timeout);
        end
        cyc(5);
        checks++;
        if (nack_end !== 1'b1 || sda_release !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: got nack=%b rel=%b want 1,1",
                     nack_end, sda_release);
        end
    endtask

    task automatic test_burst_wrap();
        logic [AW-1:0] sp;
        int n, bad;
        for (int c = 0; c < 8; c++) begin
            fill_mem();
            if (c == 0) begin
                sp = 4'd5; n = 4;
                mem[5] = 8'h11; mem[6] = 8'h22;
                mem[7] = 8'h33; mem[8] = 8'h44;
            end else if (c == 1) begin
                sp = 4'd15; n = 2;
                mem[15] = 8'hF0; mem[0] = 8'h0F;
            end else begin
                sp = 4'($urandom);
                n = $urandom_range(1, 6);
            end
            do_transfer(sp, n, 1'b0);
            bad = 0;
            if (obs_bytes.size() != n) bad++;
            else
                for (int i = 0; i < n; i++)
                    if (obs_bytes[i] !== mem[sp + 4'(i)]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL burst_bytes c%0d: got %p (%0d wrong) sp=%0d n=%0d",
                         c, obs_bytes, bad, sp, n);
            end
            bad = 0;
            if (rd_log.size() != n + 1) bad++;
            else
                for (int i = 0; i <= n; i++)
                    if (rd_log[i] !== sp + 4'(i)) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL burst_addr c%0d: got %p want %0d.. x%0d",
                         c, rd_log, sp, n + 1);
            end
            checks++;
            if (byte_cnt !== 8'(n) || nack_end !== 1'b1) begin
                failures++;
                $display("FAIL burst_cnt c%0d: got cnt=%0d nack=%b want %0d,1",
                         c, byte_cnt, nack_end, n);
            end
            checks++;
            if (obs_rel_bad != 0 || obs_ack_bad != 0 || obs_done != 1) begin
                failures++;
                $display("FAIL burst_slot c%0d: got rel_bad=%0d ack_bad=%0d done=%0d want 0,0,1",
                         c, obs_rel_bad, obs_ack_bad, obs_done);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        fill_mem();
        start_ptr = 4'd9;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_en(ok);
        shift_bits(3, 1'b0);
        stop_det = 1'b1;
        @(negedge clk);
        stop_det = 1'b0;
        checks++;
        if ({ok, byte_write_en, sda_release, done, nack_end, busy}
            !== 6'b101100) begin
            failures++;
            $display("FAIL abort_state: got ok=%b en=%b rel=%b done=%b nack=%b busy=%b want 1,0,1,1,0,0",
                     ok, byte_write_en, sda_release, done, nack_end, busy);
        end
        checks++;
        if (byte_cnt !== 8'd0) begin
            failures++;
            $display("FAIL abort_cnt: got %0d want 0", byte_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done_width: got %b want 0", done);
        end
    endtask

    task automatic test_abort_on_finish();
        bit ok;
        fill_mem();
        start_ptr = 4'd3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_en(ok);
        shift_bits(8, 1'b0);
        scl_i = 1'b0;
        byte_write_finish = 1'b1;
        stop_det = 1'b1;
        @(negedge clk);
        byte_write_finish = 1'b0;
        stop_det = 1'b0;
        checks++;
        if (byte_cnt !== 8'd0 || done !== 1'b1 || reg_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_finish: got cnt=%0d done=%b rd_en=%b want 0,1,0",
                     byte_cnt, done, reg_rd_en);
        end
        checks++;
        if ({ok, byte_write_en, sda_release, nack_end} !== 4'b1010) begin
            failures++;
            $display("FAIL abort_finish_flags: got ok=%b en=%b rel=%b nack=%b want 1,0,1,0",
                     ok, byte_write_en, sda_release, nack_end);
        end
        scl_i = 1'b1;
        cyc(3);
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] sp;
        int bad;
        fill_mem();
        sp = 4'($urandom);
        do_transfer(sp, 3, 1'b1);
        bad = 0;
        if (obs_bytes.size() != 3) bad++;
        else
            for (int i = 0; i < 3; i++)
                if (obs_bytes[i] !== mem[sp + 4'(i)]) bad++;
        checks++;
        if (bad != 0 || byte_cnt !== 8'd3 || obs_done != 1) begin
            failures++;
            $display("FAIL start_ignored: got %p cnt=%0d done=%0d sp=%0d",
                     obs_bytes, byte_cnt, obs_done, sp);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        logic [AW-1:0] sp;
        fill_mem();
        start_ptr = 4'd7;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_en(ok);
        shift_bits(3, 1'b0);
        scl_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ok, reg_rd_en, reg_rd_addr, byte_write_en, byte_write_o,
             sda_release, busy, done, nack_end, byte_cnt}
            !== {1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 4'b1000, 8'h00}) begin
            failures++;
            $display("FAIL reset_mid: got en=%b o=%h rel=%b busy=%b cnt=%0d addr=%0d want reset values",
                     byte_write_en, byte_write_o, sda_release, busy,
                     byte_cnt, reg_rd_addr);
        end
        scl_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        sp = 4'($urandom);
        do_transfer(sp, 2, 1'b0);
        checks++;
        if (obs_bytes.size() != 2 || obs_bytes[0] !== mem[sp]
            || obs_bytes[1] !== mem[sp + 4'd1] || byte_cnt !== 8'd2) begin
            failures++;
            $display("FAIL reset_then_transfer: got %p cnt=%0d want %h,%h cnt=2",
                     obs_bytes, byte_cnt, mem[sp], mem[sp + 4'd1]);
        end
    endtask

    task automatic test_saturate();
        logic [AW-1:0] sp;
        int bad;
        fill_mem();
        sp = 4'($urandom);
        do_transfer(sp, 257, 1'b0);
        bad = 0;
        if (obs_bytes.size() != 257) bad++;
        else
            for (int i = 0; i < 257; i++)
                if (obs_bytes[i] !== mem[sp + 4'(i)]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL saturate_bytes: got %0d bytes, %0d wrong, want 257",
                     obs_bytes.size(), bad);
        end
        checks++;
        if (byte_cnt !== 8'd255) begin
            failures++;
            $display("FAIL saturate_cnt: got %0d want 255", byte_cnt);
        end
    endtask

    initial begin
        cyc(3);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        test_single();
        test_burst_wrap();
        test_abort();
        test_abort_on_finish();
        test_start_ignored();
        test_reset_mid_send();
        test_saturate();
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
